rgb_bank_arbiter: RTL and testbench
===================================

Name: rgb_bank_arbiter

Overview:
- Shares the three single-port 16384x8 colour banks (R, G, B) between two requesters.
- Port A: demosaic interpolation engine. Port B: host readout / DMA path that streams the finished image out.
- Each bank is arbitrated independently every cycle, so A and B run concurrently when they target different banks.
- Per-bank round-robin resolves same-bank contention. Read data is returned to the winning requester with fixed one-cycle latency.

Parameters:
- AW, 14, bank address width (128x128 image, {row[6:0], col[6:0]})
- DW, 8, pixel data width

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- req_a  in  1  port A transaction request
- bank_a  in  2  port A bank select: 0=R, 1=G, 2=B, 3=reserved
- we_a  in  1  port A write (1) / read (0)
- addr_a  in  AW  port A address
- wdata_a  in  DW  port A write data
- gnt_a  out  1  port A accepted this cycle (combinational)
- rvalid_a  out  1  port A read data valid
- rdata_a  out  DW  port A read data
- req_b, bank_b, we_b, addr_b, wdata_b, gnt_b, rvalid_b, rdata_b: same as port A, for port B
- wr_r, wr_g, wr_b  out  1 each  bank write strobes (registered)
- addr_r, addr_g, addr_b  out  AW each  bank addresses (registered)
- wdata_r, wdata_g, wdata_b  out  DW each  bank write data (registered)
- rdata_r, rdata_g, rdata_b  in  DW each  bank read data, valid in the cycle its address is presented

Behaviour:
- Reset: all wr_*, addr_*, wdata_*, rvalid_*, rdata_* = 0. All round-robin pointers point to A. Any pending read return is discarded.
- Bank select 3: never granted. gnt stays 0 while asserted; no bank activity.
- Grant, cycle N, combinational, per bank k:
  - Only A requests k: A wins. Only B requests k: B wins.
  - Both request k: the owner of ptr[k] wins. ptr[k] flips to the loser at the next edge.
  - Uncontended grants leave ptr[k] unchanged.
- gnt_x = req_x & (x won its bank). Requester holds req/addr/wdata stable until gnt.
- Cycle N+1, registered:
  - addr_k <= winner addr. wr_k <= winner we. wdata_k <= winner wdata if write; otherwise wdata_k holds.
  - Banks with no winner: wr_k <= 0; addr_k and wdata_k hold.
- Read return:
  - A granted read at N gives rvalid_a = 1 in N+1, with rdata_a = rdata_<bank_a registered at N> (combinational mux from registered bank tag).
  - Same rule for B.
  - rdata_x holds its last value when rvalid_x = 0.
- Throughput: one transaction per port per cycle. Back-to-back reads to one bank by one port return on consecutive cycles.
- Simultaneous write by A and read by B to the same bank, same cycle: serialized by round-robin. The read issued one cycle after the write returns the new data.
- Reset asserted mid-transaction: accepted-but-unreturned reads are lost. Requesters must reissue.

Decomposition:
- Shared package rgb_mem_pkg: AW, DW, bank codes BANK_R=0, BANK_G=1, BANK_B=2, and IMG_W=128.
- Natural sub-module: rr_arb2, a 2-requester round-robin arbiter with pointer register. Instantiated three times, once per bank.
- Top level contains request decode, output registers and return steering.

Test Plan:
- Reset with reqs asserted → all outputs 0; after release, A read bank 0 addr 0x0081 → gnt_a=1 in N; addr_r=0x0081, wr_r=0 in N+1; rvalid_a=1 with rdata_a=rdata_r in N+1.
- A reads G 0x0100 while B writes B 0x0200 with data 0x5A, same cycle → both granted in N; in N+1 addr_g=0x0100, wr_b=1, addr_b=0x0200, wdata_b=0x5A.
- A and B both read R for 4 cycles, reqs held → grants A,B,A,B; each rvalid exactly one cycle after its grant.
- B write R 0x0005 = 0xC3, then A read R 0x0005 → rdata_a=0xC3 (with memory model).
- bank_a=3 held for 3 cycles → gnt_a=0 throughout; all wr_* = 0.
- Reset pulse in the cycle after an A read grant → rvalid_a=0, pointers back to A; the next contended grant goes to A.

Source files
------------

// File: rtl/rgb_mem_pkg.sv
`default_nettype none
//------------------------------------------------------------------
// rgb_mem_pkg - shared widths and bank codes for the RGB bank arbiter
// Revision: 1.0
//------------------------------------------------------------------
package rgb_mem_pkg;

  localparam int IMG_W = 128;
  localparam int AW    = $clog2(IMG_W * IMG_W);
  localparam int DW    = 8;
  localparam int NBANK = 3;

  typedef enum logic [1:0] {
    BANK_R    = 2'd0,
    BANK_G    = 2'd1,
    BANK_B    = 2'd2,
    BANK_RSVD = 2'd3
  } bank_e;

  typedef enum logic {
    OWN_A = 1'b0,
    OWN_B = 1'b1
  } owner_e;

endpackage
`default_nettype wire

// File: rtl/rgb_bank_arbiter_if.sv
`default_nettype none
//------------------------------------------------------------------
// rgb_bank_arbiter_if - one requester port of the RGB bank arbiter
// Revision: 1.0
//------------------------------------------------------------------
interface rgb_bank_arbiter_if;
  import rgb_mem_pkg::*;

  logic          req;
  logic [1:0]    bank;
  logic          we;
  logic [AW-1:0] addr;
  logic [DW-1:0] wdata;
  logic          gnt;
  logic          rvalid;
  logic [DW-1:0] rdata;

  modport master (output req, bank, we, addr, wdata, input  gnt, rvalid, rdata);
  modport slave  (input  req, bank, we, addr, wdata, output gnt, rvalid, rdata);

endinterface
`default_nettype wire

// File: rtl/rr_arb2.sv
`default_nettype none
//------------------------------------------------------------------
// rr_arb2 - two-requester round-robin arbiter with tie-owner pointer
// Revision: 1.0
//------------------------------------------------------------------
module rr_arb2
  import rgb_mem_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic i_req_a,
  input  logic i_req_b,
  output logic o_gnt_a,
  output logic o_gnt_b
);

  owner_e r_ptr;

  // The pointer only matters on a tie; a lone requester always wins.
  assign o_gnt_a = i_req_a & (~i_req_b | (r_ptr == OWN_A));
  assign o_gnt_b = i_req_b & (~i_req_a | (r_ptr == OWN_B));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ptr <= OWN_A;
    end else if (i_req_a && i_req_b) begin
      r_ptr <= (r_ptr == OWN_A) ? OWN_B : OWN_A;
    end
  end

endmodule
`default_nettype wire

// File: rtl/rgb_bank_arbiter.sv
`default_nettype none
//------------------------------------------------------------------
// rgb_bank_arbiter - shares R/G/B single-port banks between two ports
// Revision: 1.0
//------------------------------------------------------------------
module rgb_bank_arbiter
  import rgb_mem_pkg::*;
(
  input  logic                clk,
  input  logic                reset,
  rgb_bank_arbiter_if.slave   port_a,
  rgb_bank_arbiter_if.slave   port_b,
  output logic                wr_r,
  output logic                wr_g,
  output logic                wr_b,
  output logic [AW-1:0]       addr_r,
  output logic [AW-1:0]       addr_g,
  output logic [AW-1:0]       addr_b,
  output logic [DW-1:0]       wdata_r,
  output logic [DW-1:0]       wdata_g,
  output logic [DW-1:0]       wdata_b,
  input  logic [DW-1:0]       rdata_r,
  input  logic [DW-1:0]       rdata_g,
  input  logic [DW-1:0]       rdata_b
);

  logic [NBANK-1:0]         w_req_a;
  logic [NBANK-1:0]         w_req_b;
  logic [NBANK-1:0]         w_gnt_a;
  logic [NBANK-1:0]         w_gnt_b;
  logic                     w_gnt_any_a;
  logic                     w_gnt_any_b;

  logic [NBANK-1:0]         r_wr;
  logic [NBANK-1:0][AW-1:0] r_addr;
  logic [NBANK-1:0][DW-1:0] r_wdata;

  logic                     r_rv_a;
  logic                     r_rv_b;
  logic [1:0]               r_tag_a;
  logic [1:0]               r_tag_b;
  logic [DW-1:0]            r_hold_a;
  logic [DW-1:0]            r_hold_b;
  logic [DW-1:0]            w_sel_a;
  logic [DW-1:0]            w_sel_b;

  // Requests are masked during reset so no grant is shown and no pointer moves.
  generate
    for (genvar k = 0; k < NBANK; k++) begin : g_bank
      assign w_req_a[k] = port_a.req & ~reset & (port_a.bank == 2'(k));
      assign w_req_b[k] = port_b.req & ~reset & (port_b.bank == 2'(k));

      rr_arb2 u_arb (
        .clk     (clk),
        .reset   (reset),
        .i_req_a (w_req_a[k]),
        .i_req_b (w_req_b[k]),
        .o_gnt_a (w_gnt_a[k]),
        .o_gnt_b (w_gnt_b[k])
      );
    end
  endgenerate

  assign w_gnt_any_a = |w_gnt_a;
  assign w_gnt_any_b = |w_gnt_b;
  assign port_a.gnt  = w_gnt_any_a;
  assign port_b.gnt  = w_gnt_any_b;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr    <= '0;
      r_addr  <= '0;
      r_wdata <= '0;
    end else begin
      for (int k = 0; k < NBANK; k++) begin
        if (w_gnt_a[k]) begin
          r_wr[k]   <= port_a.we;
          r_addr[k] <= port_a.addr;
          if (port_a.we) r_wdata[k] <= port_a.wdata;
        end else if (w_gnt_b[k]) begin
          r_wr[k]   <= port_b.we;
          r_addr[k] <= port_b.addr;
          if (port_b.we) r_wdata[k] <= port_b.wdata;
        end else begin
          r_wr[k]   <= 1'b0;
        end
      end
    end
  end

  assign wr_r    = r_wr[BANK_R];
  assign wr_g    = r_wr[BANK_G];
  assign wr_b    = r_wr[BANK_B];
  assign addr_r  = r_addr[BANK_R];
  assign addr_g  = r_addr[BANK_G];
  assign addr_b  = r_addr[BANK_B];
  assign wdata_r = r_wdata[BANK_R];
  assign wdata_g = r_wdata[BANK_G];
  assign wdata_b = r_wdata[BANK_B];

  // The bank tag remembers where the accepted read went; the data arrives next cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rv_a   <= 1'b0;
      r_rv_b   <= 1'b0;
      r_tag_a  <= 2'd0;
      r_tag_b  <= 2'd0;
      r_hold_a <= '0;
      r_hold_b <= '0;
    end else begin
      r_rv_a <= w_gnt_any_a & ~port_a.we;
      r_rv_b <= w_gnt_any_b & ~port_b.we;
      if (w_gnt_any_a && !port_a.we) r_tag_a <= port_a.bank;
      if (w_gnt_any_b && !port_b.we) r_tag_b <= port_b.bank;
      if (r_rv_a) r_hold_a <= w_sel_a;
      if (r_rv_b) r_hold_b <= w_sel_b;
    end
  end

  always_comb begin
    w_sel_a = '0;
    case (r_tag_a)
      BANK_R:  w_sel_a = rdata_r;
      BANK_G:  w_sel_a = rdata_g;
      BANK_B:  w_sel_a = rdata_b;
      default: w_sel_a = '0;
    endcase
  end

  always_comb begin
    w_sel_b = '0;
    case (r_tag_b)
      BANK_R:  w_sel_b = rdata_r;
      BANK_G:  w_sel_b = rdata_g;
      BANK_B:  w_sel_b = rdata_b;
      default: w_sel_b = '0;
    endcase
  end

  assign port_a.rvalid = r_rv_a;
  assign port_b.rvalid = r_rv_b;
  assign port_a.rdata  = r_rv_a ? w_sel_a : r_hold_a;
  assign port_b.rdata  = r_rv_b ? w_sel_b : r_hold_b;

endmodule
`default_nettype wire

// File: tb/tb_rgb_bank_arbiter.sv
`default_nettype none
//------------------------------------------------------------------
// tb_rgb_bank_arbiter - directed and randomized bench for rgb_bank_arbiter
// Revision: 1.0
//------------------------------------------------------------------
module tb_rgb_bank_arbiter;
  import rgb_mem_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  rgb_bank_arbiter_if pa ();
  rgb_bank_arbiter_if pb ();

  logic          wr_r, wr_g, wr_b;
  logic [AW-1:0] addr_r, addr_g, addr_b;
  logic [DW-1:0] wdata_r, wdata_g, wdata_b;
  logic [DW-1:0] rdata_r, rdata_g, rdata_b;

  // Physical bank contents seen by the DUT; written only from the stimulus process.
  logic [DW-1:0] mem     [3][1<<AW];
  logic [DW-1:0] ref_mem [3][1<<AW];

  assign rdata_r = mem[0][addr_r];
  assign rdata_g = mem[1][addr_g];
  assign rdata_b = mem[2][addr_b];

  logic          t_wr    [3];
  logic [AW-1:0] t_addr  [3];
  logic [DW-1:0] t_wdata [3];
  assign t_wr[0] = wr_r;       assign t_wr[1] = wr_g;       assign t_wr[2] = wr_b;
  assign t_addr[0] = addr_r;   assign t_addr[1] = addr_g;   assign t_addr[2] = addr_b;
  assign t_wdata[0] = wdata_r; assign t_wdata[1] = wdata_g; assign t_wdata[2] = wdata_b;

  rgb_bank_arbiter dut (
    .clk     (clk),
    .reset   (reset),
    .port_a  (pa),
    .port_b  (pb),
    .wr_r    (wr_r),
    .wr_g    (wr_g),
    .wr_b    (wr_b),
    .addr_r  (addr_r),
    .addr_g  (addr_g),
    .addr_b  (addr_b),
    .wdata_r (wdata_r),
    .wdata_g (wdata_g),
    .wdata_b (wdata_b),
    .rdata_r (rdata_r),
    .rdata_g (rdata_g),
    .rdata_b (rdata_b)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: who owns the next tie per bank, plus expected observables.
  bit            pref [3];
  bit            e_gnt_a, e_gnt_b, e_rv_a, e_rv_b;
  logic [DW-1:0] e_rd_a, e_rd_b;
  bit            e_wr [3];
  logic [AW-1:0] e_addr [3];
  logic [DW-1:0] e_wdata [3];
  int            ka, kb;

  task automatic model_reset();
    for (int k = 0; k < 3; k++) begin
      pref[k] = 1'b0; e_wr[k] = 1'b0; e_addr[k] = '0; e_wdata[k] = '0;
    end
    e_rv_a = 1'b0; e_rv_b = 1'b0; e_rd_a = '0; e_rd_b = '0;
    e_gnt_a = 1'b0; e_gnt_b = 1'b0;
  endtask

  task automatic eval();
    ka = (pa.req && !reset && pa.bank != 2'd3) ? int'(pa.bank) : -1;
    kb = (pb.req && !reset && pb.bank != 2'd3) ? int'(pb.bank) : -1;
    e_gnt_a = (ka >= 0) && ((kb != ka) || !pref[ka]);
    e_gnt_b = (kb >= 0) && ((ka != kb) || pref[kb]);
  endtask

  task automatic commit();
    if (!reset) begin
      for (int k = 0; k < 3; k++) e_wr[k] = 1'b0;
      if (ka >= 0 && ka == kb) pref[ka] = !pref[ka];
      e_rv_a = 1'b0;
      e_rv_b = 1'b0;
      if (e_gnt_a) begin
        e_addr[ka] = pa.addr; e_wr[ka] = pa.we;
        if (pa.we) begin e_wdata[ka] = pa.wdata; ref_mem[ka][pa.addr] = pa.wdata; end
        else begin e_rv_a = 1'b1; e_rd_a = ref_mem[ka][pa.addr]; end
      end
      if (e_gnt_b) begin
        e_addr[kb] = pb.addr; e_wr[kb] = pb.we;
        if (pb.we) begin e_wdata[kb] = pb.wdata; ref_mem[kb][pb.addr] = pb.wdata; end
        else begin e_rv_b = 1'b1; e_rd_b = ref_mem[kb][pb.addr]; end
      end
    end
    for (int k = 0; k < 3; k++) if (t_wr[k]) mem[k][t_addr[k]] = t_wdata[k];
    @(posedge clk);
    #1;
  endtask

  task automatic drive_a(input bit rq, input logic [1:0] bk, input bit w,
                         input logic [AW-1:0] ad, input logic [DW-1:0] wd);
    pa.req = rq; pa.bank = bk; pa.we = w; pa.addr = ad; pa.wdata = wd;
  endtask

  task automatic drive_b(input bit rq, input logic [1:0] bk, input bit w,
                         input logic [AW-1:0] ad, input logic [DW-1:0] wd);
    pb.req = rq; pb.bank = bk; pb.we = w; pb.addr = ad; pb.wdata = wd;
  endtask

  task automatic test_reset();
    drive_a(1'b1, BANK_R, 1'b1, 14'h0010, 8'hFF);
    drive_b(1'b1, BANK_G, 1'b1, 14'h0020, 8'hEE);
    reset = 1'b1;
    model_reset();
    commit();
    @(negedge clk); eval();
    n_tests++;
    if ({pa.gnt, pb.gnt} !== 2'b00) begin
      n_fail++; $display("FAIL reset_gnt: got %b want 00", {pa.gnt, pb.gnt});
    end
    n_tests++;
    if ({wr_r, wr_g, wr_b, addr_r, addr_g, addr_b, wdata_r, wdata_g, wdata_b} !== '0) begin
      n_fail++; $display("FAIL reset_bank: wr=%b%b%b addr=%h/%h/%h wdata=%h/%h/%h want all 0",
                         wr_r, wr_g, wr_b, addr_r, addr_g, addr_b, wdata_r, wdata_g, wdata_b);
    end
    n_tests++;
    if ({pa.rvalid, pb.rvalid, pa.rdata, pb.rdata} !== '0) begin
      n_fail++; $display("FAIL reset_ret: rvalid=%b%b rdata=%h/%h want 0", pa.rvalid, pb.rvalid, pa.rdata, pb.rdata);
    end
    commit();
    reset = 1'b0;
    drive_a(1'b1, BANK_R, 1'b0, 14'h0081, 8'h00);
    drive_b(1'b0, BANK_R, 1'b0, 14'h0000, 8'h00);
    @(negedge clk); eval();
    n_tests++;
    if (pa.gnt !== 1'b1) begin n_fail++; $display("FAIL first_gnt_a: got %b want 1", pa.gnt); end
    commit();
    drive_a(1'b0, BANK_R, 1'b0, 14'h0000, 8'h00);
    @(negedge clk); eval();
    n_tests++;
    if (addr_r !== 14'h0081 || wr_r !== 1'b0) begin
      n_fail++; $display("FAIL first_bank_r: addr=%h wr=%b want 0081/0", addr_r, wr_r);
    end
    n_tests++;
    if (pa.rvalid !== 1'b1 || pa.rdata !== ref_mem[0][14'h0081]) begin
      n_fail++; $display("FAIL first_ret_a: rvalid=%b rdata=%h want 1/%h", pa.rvalid, pa.rdata, ref_mem[0][14'h0081]);
    end
    commit();
  endtask

  task automatic test_concurrent();
    drive_a(1'b1, BANK_G, 1'b0, 14'h0100, 8'h00);
    drive_b(1'b1, BANK_B, 1'b1, 14'h0200, 8'h5A);
    @(negedge clk); eval();
    n_tests++;
    if ({pa.gnt, pb.gnt} !== 2'b11) begin n_fail++; $display("FAIL conc_gnt: got %b want 11", {pa.gnt, pb.gnt}); end
    commit();
    drive_a(1'b0, BANK_R, 1'b0, 14'h0000, 8'h00);
    drive_b(1'b0, BANK_R, 1'b0, 14'h0000, 8'h00);
    @(negedge clk); eval();
    n_tests++;
    if (addr_g !== 14'h0100 || wr_g !== 1'b0 || wr_b !== 1'b1 || addr_b !== 14'h0200 || wdata_b !== 8'h5A) begin
      n_fail++; $display("FAIL conc_bank: addr_g=%h wr_g=%b wr_b=%b addr_b=%h wdata_b=%h want 0100/0/1/0200/5a",
                         addr_g, wr_g, wr_b, addr_b, wdata_b);
    end
    n_tests++;
    if (pa.rvalid !== 1'b1 || pa.rdata !== e_rd_a || pb.rvalid !== 1'b0) begin
      n_fail++; $display("FAIL conc_ret: rvalid_a=%b rdata_a=%h rvalid_b=%b want 1/%h/0", pa.rvalid, pa.rdata, pb.rvalid, e_rd_a);
    end
    commit();
  endtask

  task automatic test_back_to_back();
    bit ga, gb, pga, pgb;
    reset = 1'b1; model_reset(); commit(); reset = 1'b0;
    pga = 1'b0; pgb = 1'b0;
    for (int i = 0; i < 6; i++) begin
      if (i < 4) begin
        drive_a(1'b1, BANK_R, 1'b0, 14'h0011, 8'h00);
        drive_b(1'b1, BANK_R, 1'b0, 14'h0022, 8'h00);
      end else begin
        drive_a(1'b0, BANK_R, 1'b0, 14'h0000, 8'h00);
        drive_b(1'b0, BANK_R, 1'b0, 14'h0000, 8'h00);
      end
      ga = (i < 4) && (i % 2 == 0);
      gb = (i < 4) && (i % 2 == 1);
      @(negedge clk); eval();
      n_tests++;
      if (pa.gnt !== ga || pb.gnt !== gb) begin
        n_fail++; $display("FAIL rr_gnt[%0d]: got %b%b want %b%b", i, pa.gnt, pb.gnt, ga, gb);
      end
      n_tests++;
      if (pa.rvalid !== pga || pb.rvalid !== pgb) begin
        n_fail++; $display("FAIL rr_rvalid[%0d]: got %b%b want %b%b", i, pa.rvalid, pb.rvalid, pga, pgb);
      end
      if (pga) begin
        n_tests++;
        if (pa.rdata !== ref_mem[0][14'h0011]) begin
          n_fail++; $display("FAIL rr_rdata_a[%0d]: got %h want %h", i, pa.rdata, ref_mem[0][14'h0011]);
        end
      end
      pga = ga; pgb = gb;
      commit();
    end
    // One port streaming reads to one bank: returns on consecutive cycles.
    for (int i = 0; i < 5; i++) begin
      if (i < 4) drive_a(1'b1, BANK_B, 1'b0, 14'(16'h0300 + i), 8'h00);
      else       drive_a(1'b0, BANK_B, 1'b0, 14'h0000, 8'h00);
      @(negedge clk); eval();
      if (i > 0) begin
        n_tests++;
        if (pa.rvalid !== 1'b1 || pa.rdata !== ref_mem[2][14'(16'h0300 + i - 1)]) begin
          n_fail++; $display("FAIL stream_a[%0d]: rvalid=%b rdata=%h want 1/%h", i, pa.rvalid, pa.rdata,
                             ref_mem[2][14'(16'h0300 + i - 1)]);
        end
      end
      commit();
    end
  endtask

  task automatic test_raw();
    drive_b(1'b1, BANK_R, 1'b1, 14'h0005, 8'hC3);
    @(negedge clk); eval();
    n_tests++;
    if (pb.gnt !== 1'b1) begin n_fail++; $display("FAIL raw_wgnt: got %b want 1", pb.gnt); end
    commit();
    drive_b(1'b0, BANK_R, 1'b0, 14'h0000, 8'h00);
    drive_a(1'b1, BANK_R, 1'b0, 14'h0005, 8'h00);
    @(negedge clk); eval();
    n_tests++;
    if (pa.gnt !== 1'b1) begin n_fail++; $display("FAIL raw_rgnt: got %b want 1", pa.gnt); end
    commit();
    drive_a(1'b0, BANK_R, 1'b0, 14'h0000, 8'h00);
    @(negedge clk); eval();
    n_tests++;
    if (pa.rvalid !== 1'b1 || pa.rdata !== 8'hC3) begin
      n_fail++; $display("FAIL raw_data: rvalid=%b rdata=%h want 1/c3", pa.rvalid, pa.rdata);
    end
    commit();
  endtask

  task automatic test_reserved();
    drive_b(1'b0, BANK_R, 1'b0, 14'h0000, 8'h00);
    for (int i = 0; i < 3; i++) begin
      drive_a(1'b1, BANK_RSVD, 1'b1, 14'h0007, 8'h99);
      @(negedge clk); eval();
      n_tests++;
      if (pa.gnt !== 1'b0 || {wr_r, wr_g, wr_b} !== 3'b000) begin
        n_fail++; $display("FAIL reserved[%0d]: gnt_a=%b wr=%b%b%b want 0/000", i, pa.gnt, wr_r, wr_g, wr_b);
      end
      commit();
    end
    drive_a(1'b0, BANK_R, 1'b0, 14'h0000, 8'h00);
  endtask

  task automatic test_midreset();
    drive_a(1'b1, BANK_R, 1'b0, 14'h0033, 8'h00);
    drive_b(1'b0, BANK_R, 1'b0, 14'h0000, 8'h00);
    @(negedge clk); eval();
    n_tests++;
    if (pa.gnt !== 1'b1) begin n_fail++; $display("FAIL mid_gnt: got %b want 1", pa.gnt); end
    commit();
    reset = 1'b1;
    model_reset();
    #2;
    n_tests++;
    if (pa.rvalid !== 1'b0 || pa.rdata !== 8'h00) begin
      n_fail++; $display("FAIL mid_drop: rvalid=%b rdata=%h want 0/00", pa.rvalid, pa.rdata);
    end
    drive_a(1'b1, BANK_R, 1'b0, 14'h0040, 8'h00);
    drive_b(1'b1, BANK_R, 1'b0, 14'h0041, 8'h00);
    #1;
    reset = 1'b0;
    @(negedge clk); eval();
    n_tests++;
    if (pa.gnt !== 1'b1 || pb.gnt !== 1'b0) begin
      n_fail++; $display("FAIL mid_ptr: gnt=%b%b want 10", pa.gnt, pb.gnt);
    end
    commit();
    drive_a(1'b0, BANK_R, 1'b0, 14'h0000, 8'h00);
    drive_b(1'b0, BANK_R, 1'b0, 14'h0000, 8'h00);
    @(negedge clk); eval();
    n_tests++;
    if (pa.rvalid !== 1'b1 || pa.rdata !== ref_mem[0][14'h0040]) begin
      n_fail++; $display("FAIL mid_ret: rvalid=%b rdata=%h want 1/%h", pa.rvalid, pa.rdata, ref_mem[0][14'h0040]);
    end
    commit();
  endtask

  task automatic test_random();
    bit            pa_p, pb_p, la, lb, wa, wb;
    logic [1:0]    ba, bb;
    logic [AW-1:0] aa, ab;
    logic [DW-1:0] da, db;
    pa_p = 0; pb_p = 0; la = 0; lb = 0; ba = 0; bb = 0;
    wa = 0; wb = 0; aa = '0; ab = '0; da = '0; db = '0;
    for (int c = 0; c < 400; c++) begin
      if (!pa_p || la || ba == 2'd3) begin
        pa_p = ($urandom_range(0, 3) != 0);
        ba = ($urandom_range(0, 11) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
        wa = 1'($urandom_range(0, 1)); aa = 14'($urandom_range(0, 15)); da = 8'($urandom);
      end
      if (!pb_p || lb || bb == 2'd3) begin
        pb_p = ($urandom_range(0, 3) != 0);
        bb = ($urandom_range(0, 11) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
        wb = 1'($urandom_range(0, 1)); ab = 14'($urandom_range(0, 15)); db = 8'($urandom);
      end
      drive_a(pa_p, ba, wa, aa, da);
      drive_b(pb_p, bb, wb, ab, db);
      @(negedge clk); eval();
      n_tests++;
      if (pa.gnt !== e_gnt_a || pb.gnt !== e_gnt_b) begin
        n_fail++; $display("FAIL rnd_gnt[%0d]: got %b%b want %b%b", c, pa.gnt, pb.gnt, e_gnt_a, e_gnt_b);
      end
      n_tests++;
      if (pa.rvalid !== e_rv_a || pa.rdata !== e_rd_a || pb.rvalid !== e_rv_b || pb.rdata !== e_rd_b) begin
        n_fail++; $display("FAIL rnd_ret[%0d]: a=%b/%h b=%b/%h want a=%b/%h b=%b/%h", c, pa.rvalid, pa.rdata,
                           pb.rvalid, pb.rdata, e_rv_a, e_rd_a, e_rv_b, e_rd_b);
      end
      for (int k = 0; k < 3; k++) begin
        n_tests++;
        if (t_wr[k] !== e_wr[k] || t_addr[k] !== e_addr[k] || t_wdata[k] !== e_wdata[k]) begin
          n_fail++; $display("FAIL rnd_bank%0d[%0d]: wr=%b addr=%h wdata=%h want %b/%h/%h", k, c,
                             t_wr[k], t_addr[k], t_wdata[k], e_wr[k], e_addr[k], e_wdata[k]);
        end
      end
      la = e_gnt_a;
      lb = e_gnt_b;
      commit();
    end
  endtask

  initial begin
    logic [DW-1:0] v;
    for (int k = 0; k < 3; k++) begin
      for (int i = 0; i < (1 << AW); i++) begin
        v = 8'($urandom);
        mem[k][i] = v;
        ref_mem[k][i] = v;
      end
    end
    drive_a(1'b0, BANK_R, 1'b0, 14'h0000, 8'h00);
    drive_b(1'b0, BANK_R, 1'b0, 14'h0000, 8'h00);
    model_reset();
    ka = -1; kb = -1;
    @(posedge clk); #1;
    test_reset();
    test_concurrent();
    test_back_to_back();
    test_raw();
    test_reserved();
    test_midreset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
